uniform_compactor: RTL
======================

UNIFORM_COMPACTOR -- requirements
Module: uniform_compactor

Interface
REQ-001 SHALL have parameter LANES, default 8, meaning parallel sample lanes per input word.
REQ-002 SHALL have parameter CAND_BITS, default 16, meaning width of one coefficient.
REQ-003 SHALL have parameter N_COEFFS, default 256, meaning coefficients per polynomial, power of two.
REQ-004 SHALL have parameter DEPTH, default 64, meaning FIFO entries, power of two, at least 2*LANES.
REQ-005 SHALL have parameter PIPE_SLACK, default 4, meaning upstream in-flight words tolerated after accept_en falls.
REQ-006 SHALL have ports: clk in 1, clock; rst_n in 1, reset.
REQ-007 SHALL have ports: start in 1, begin polynomial; sampled_vals in LANES*CAND_BITS, lane values with lane 0 in the LSBs; sampled_valid in LANES, per-lane accept; retry_mask in LANES, per-lane reject.
REQ-008 SHALL have ports: accept_en out 1, upstream may issue random words; coeff_data out CAND_BITS; coeff_valid out 1; coeff_ready in 1; coeff_idx out log2(N_COEFFS), index of coeff_data.
REQ-009 SHALL have ports: poly_done out 1, one-cycle pulse; busy out 1; overflow out 1, sticky; retry_cnt out 16, saturating reject count.
REQ-010 SHALL state: reset rst_n, asynchronous, active-low; clock clk.

Function
REQ-011 SHALL implement FSM IDLE, FILL, DRAIN, DONE; busy is high in FILL and DRAIN.
REQ-012 IDLE with start=1 SHALL enter FILL and clear wr_cnt, rd_cnt, retry_cnt, overflow and the FIFO; start outside IDLE SHALL be ignored.
REQ-013 In FILL, each cycle SHALL write the set lanes of sampled_valid into the FIFO in ascending lane order, up to the remaining need N_COEFFS-wr_cnt; excess lanes SHALL be discarded without setting overflow.
REQ-014 wr_cnt reaching N_COEFFS SHALL move FILL to DRAIN on the next edge; in DRAIN and IDLE, sampled_valid SHALL be ignored.
REQ-015 A write SHALL set overflow and drop the entire word, writing no lanes, when its accepted lane count exceeds FIFO free space.
REQ-016 accept_en SHALL be high iff state is FILL and free space >= LANES*(PIPE_SLACK+1) and wr_cnt < N_COEFFS.
REQ-017 coeff_valid SHALL be high iff the FIFO is non-empty; a value written at edge t SHALL be visible on coeff_data at t+1.
REQ-018 A pop SHALL occur on coeff_valid && coeff_ready; coeff_data and coeff_idx SHALL hold stable while coeff_valid && !coeff_ready.
REQ-019 coeff_idx SHALL equal rd_cnt modulo N_COEFFS, so the first output of a polynomial has index 0.
REQ-020 The same-cycle write of k entries and pop of 1 SHALL yield occupancy +k-1; pointers SHALL wrap modulo DEPTH.
REQ-021 In DRAIN, the pop that brings rd_cnt to N_COEFFS SHALL move to DONE; DONE SHALL assert poly_done for one cycle, then return to IDLE.
REQ-022 In FILL, retry_cnt SHALL add popcount(retry_mask) each cycle, saturating at 16'hFFFF.
REQ-023 wr_cnt and rd_cnt SHALL be log2(N_COEFFS)+1 bits wide; occupancy SHALL be log2(DEPTH)+1 bits wide.

Reset
REQ-024 Asserting rst_n low SHALL asynchronously force IDLE and empty the FIFO.
REQ-025 During reset, every count and output SHALL be zero: accept_en, coeff_valid, coeff_data, coeff_idx, poly_done, busy, overflow, retry_cnt, wr_cnt, rd_cnt.
REQ-026 Reset asserted mid-polynomial SHALL discard all buffered coefficients; the output SHALL stay idle after release until a new start.

Structure
REQ-027 A shared package uniform_pkg SHALL hold the state enum, LANES, CAND_BITS and N_COEFFS defaults, and the popcount function.
REQ-028 A sub-module uniform_lane_compact SHALL combinationally map the valid mask plus a limit to packed values and a count, using a prefix sum.
REQ-029 FIFO storage SHALL be inlined as a register array with a multi-write port and a single read port.

Verification
REQ-030 Scenario: start, then 32 words with sampled_valid=8'hFF and coeff_ready=1 -> 256 coeffs emitted in lane order, coeff_idx 0..255, poly_done once, overflow=0.
REQ-031 Scenario: sampled_valid=8'b1010_0101, lanes holding 0..7 -> FIFO receives 0,2,5,7 in order; retry_mask=8'b0101_1010 gives retry_cnt +4.
REQ-032 Scenario: wr_cnt=254 and next word valid=8'hFF -> only lanes 0 and 1 written; state DRAIN; accept_en=0.
REQ-033 Scenario: coeff_ready=0 for 20 cycles with full-valid words -> accept_en falls at occupancy >24; data held stable; no overflow with <=4 in-flight words.
REQ-034 Scenario: forced 6 extra full words after accept_en falls with coeff_ready=0 -> the word that does not fit is dropped whole; overflow=1 until the next start.
REQ-035 Scenario: rst_n pulsed low at wr_cnt=100 -> all outputs are 0 immediately; after release, start yields coeff_idx restarting at 0.

Source files
------------

// File: rtl/uniform_pkg.sv
// rtl/uniform_pkg.sv - shared state type, parameter defaults and popcount helper
package uniform_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int LANES_DEF     = 8;
  localparam int CAND_BITS_DEF = 16;
  localparam int N_COEFFS_DEF  = 256;

  function automatic int popcount(input logic [63:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) n = n + (v[i] ? 1 : 0);
    return n;
  endfunction

endpackage

// File: rtl/uniform_lane_compact.sv
// rtl/uniform_lane_compact.sv - packs the set lanes of a word to the low slots, capped at a limit
module uniform_lane_compact
  import uniform_pkg::*;
#(
  parameter int LANES     = LANES_DEF,
  parameter int CAND_BITS = CAND_BITS_DEF,
  parameter int CW        = $clog2(LANES + 1)
) (
  input  logic [LANES*CAND_BITS-1:0] vals,
  input  logic [LANES-1:0]           valid,
  input  logic [CW-1:0]              limit,
  output logic [LANES*CAND_BITS-1:0] packed_vals,
  output logic [CW-1:0]              count
);

  // Running prefix sum of accepted lanes gives each lane its destination slot.
  always_comb begin
    packed_vals = '0;
    count       = '0;
    for (int i = 0; i < LANES; i++) begin
      if (valid[i] && (count < limit)) begin
        packed_vals[count*CAND_BITS +: CAND_BITS] = vals[i*CAND_BITS +: CAND_BITS];
        count = count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/uniform_compactor.sv
// rtl/uniform_compactor.sv - compacts sparse accepted samples into an ordered coefficient stream
module uniform_compactor
  import uniform_pkg::*;
#(
  parameter int LANES      = LANES_DEF,
  parameter int CAND_BITS  = CAND_BITS_DEF,
  parameter int N_COEFFS   = N_COEFFS_DEF,
  parameter int DEPTH      = 64,
  parameter int PIPE_SLACK = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [LANES*CAND_BITS-1:0]    sampled_vals,
  input  logic [LANES-1:0]              sampled_valid,
  input  logic [LANES-1:0]              retry_mask,
  output logic                          accept_en,
  output logic [CAND_BITS-1:0]          coeff_data,
  output logic                          coeff_valid,
  input  logic                          coeff_ready,
  output logic [$clog2(N_COEFFS)-1:0]   coeff_idx,
  output logic                          poly_done,
  output logic                          busy,
  output logic                          overflow,
  output logic [15:0]                   retry_cnt
);

  localparam int IW        = $clog2(N_COEFFS);
  localparam int NW        = IW + 1;
  localparam int AW        = $clog2(DEPTH);
  localparam int FW        = AW + 1;
  localparam int CW        = $clog2(LANES + 1);
  localparam int LOW_WATER = LANES * (PIPE_SLACK + 1);

  state_t                   state;
  logic [NW-1:0]            wr_cnt, rd_cnt, need;
  logic [FW-1:0]            occ, free;
  logic [AW-1:0]            wptr, rptr;
  logic [CAND_BITS-1:0]     mem [DEPTH];
  logic [CW-1:0]            limit, cnt;
  logic [LANES*CAND_BITS-1:0] packed_vals;
  logic                     fill, pop, fits, do_write;
  int                       retry_sum;

  assign fill  = (state == FILL);
  assign need  = NW'(N_COEFFS) - wr_cnt;
  assign limit = (need >= NW'(LANES)) ? CW'(LANES) : CW'(need);
  assign free  = FW'(DEPTH) - occ;

  uniform_lane_compact #(
    .LANES     (LANES),
    .CAND_BITS (CAND_BITS),
    .CW        (CW)
  ) u_compact (
    .vals        (sampled_vals),
    .valid       (fill ? sampled_valid : '0),
    .limit       (limit),
    .packed_vals (packed_vals),
    .count       (cnt)
  );

  // A word either lands whole or not at all, so the stream never skips mid-word.
  assign fits     = (FW'(cnt) <= free);
  assign do_write = fill && (cnt != '0) && fits;

  assign coeff_valid = (occ != '0);
  assign pop         = coeff_valid && coeff_ready;
  assign coeff_data  = coeff_valid ? mem[rptr] : '0;
  assign coeff_idx   = rd_cnt[IW-1:0];
  assign busy        = fill || (state == DRAIN);
  assign poly_done   = (state == DONE);
  assign accept_en   = fill && (32'(free) >= 32'(LOW_WATER)) && (wr_cnt < NW'(N_COEFFS));
  assign retry_sum   = int'(retry_cnt) + popcount(64'(retry_mask));

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int j = 0; j < LANES; j++) begin
        if (j < int'(cnt)) mem[wptr + AW'(j)] <= packed_vals[j*CAND_BITS +: CAND_BITS];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      occ       <= '0;
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      retry_cnt <= '0;
    end else begin
      occ <= occ + (do_write ? FW'(cnt) : FW'(0)) - FW'(pop);
      if (pop) begin
        rptr   <= rptr + AW'(1);
        rd_cnt <= rd_cnt + NW'(1);
      end
      if (do_write) begin
        wptr   <= wptr + AW'(cnt);
        wr_cnt <= wr_cnt + NW'(cnt);
      end
      if (fill && !fits) overflow <= 1'b1;

      case (state)
        IDLE: if (start) begin
          state     <= FILL;
          wr_cnt    <= '0;
          rd_cnt    <= '0;
          occ       <= '0;
          wptr      <= '0;
          rptr      <= '0;
          overflow  <= 1'b0;
          retry_cnt <= '0;
        end
        FILL: begin
          retry_cnt <= (retry_sum > 65535) ? 16'hFFFF : retry_sum[15:0];
          if (wr_cnt == NW'(N_COEFFS)) state <= DRAIN;
        end
        // The last pop may already have happened on the FILL->DRAIN edge.
        DRAIN: if ((rd_cnt == NW'(N_COEFFS)) || (pop && (rd_cnt == NW'(N_COEFFS - 1)))) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
